muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised RV M-extension execute unit: MUL/MULH/MULHSU/MULHU (fixed-latency pipeline) and
//  DIV/DIVU/REM/REMU (iterative radix-2, 1 quotient bit/cycle). Sits in the EX stage beside the ALU.
//  Replaces the fixed 2-cycle mul_unit: adds division, valid/ready handshake, flush, busy.
// PARAMETERS
//  XLEN        32  operand/result width (>=4, even)
//  MUL_LATENCY 2   cycles from accept edge to valid_o for multiply ops (>=1)
// PORTS
//  clk       in   1     clock
//  reset_n   in   1     async active-low reset
//  stall_i   in   1     pipeline stall: freeze all internal state and outputs
//  flush_i   in   1     abort in-flight op, discard result
//  valid_i   in   1     op request
//  ready_o   out  1     unit can accept (comb: state==IDLE && !stall_i && !flush_i)
//  funct3_i  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_i     in   XLEN  operand A (signed per op)
//  rs2_i     in   XLEN  operand B
//  valid_o   out  1     result valid
//  result_o  out  XLEN  result
//  busy_o    out  1     op in flight (state!=IDLE)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): state IDLE, valid_o=0, result_o=0, busy_o=0, counters 0.
//  - Accept on rising edge with valid_i && ready_o; funct3/rs1/rs2 latched; inputs ignored after.
//  - FSM: IDLE -> MUL (count MUL_LATENCY) -> DONE; IDLE -> DIV_CALC (XLEN iters) -> DIV_FIX -> DONE;
//    IDLE -> DIV_FIX direct on special case; DONE -> IDLE when !stall_i.
//  - valid_o high exactly in DONE; one cycle if stall_i low, held with result_o while stall_i high.
//  - Latency (accept edge to valid_o): mul = MUL_LATENCY; div/rem = XLEN+2; special case = 2.
//  - Multiply: 2*XLEN product; MUL low half; MULH s*s, MULHSU s*u, MULHU u*u high half.
//  - Divide: magnitudes into unsigned restoring core; DIV_FIX applies signs:
//    quotient negated if signs differ (DIV), remainder takes dividend sign (REM).
//  - Div by zero: quotient all-ones, remainder = rs1 (all four ops).
//  - Signed overflow (rs1=-2^(XLEN-1), rs2=-1, DIV/REM): quotient = rs1, remainder 0.
//  - stall_i: every register holds; cycle counts extend by stall cycles; ready_o=0.
//  - flush_i: next edge -> IDLE, valid_o=0, no result; flush beats stall and same-cycle valid_i.
//  - valid_i while busy: not accepted (ready_o=0), requester holds.
//  - Back-to-back: new op accepted the cycle after DONE (ready_o high in IDLE).
// STRUCTURE
//  - muldiv_pkg: muldiv_op_e (funct3 encodings), muldiv_state_e {IDLE,MUL,DIV_CALC,DIV_FIX,DONE},
//    helpers is_div(op), is_signed_a(op), is_signed_b(op).
//  - Sub-module div_iter #(XLEN): unsigned restoring divider; start/stall/flush in,
//    done, quotient, remainder out; XLEN cycles. Multiplier pipeline inline (shift register,
//    MUL_LATENCY-1 stages after product).
// TESTING
//  1 XLEN=4: MUL rs1=0xB(-5) rs2=0x7 -> result 0xD after 2 cycles; MULH same -> 0xD;
//    MULHSU rs1=0xD rs2=0xA -> 0xE; MULHU 13*10 -> 0x8.
//  2 XLEN=32: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU -> 2; valid_o at XLEN+2.
//  3 Specials: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//    REM -> 0; valid_o 2 cycles after accept.
//  4 Stall: 3 stall cycles mid-DIV -> valid_o at XLEN+5, same result; stall in DONE holds valid_o/result.
//  5 Flush at cycle 10 of DIV -> no valid_o, ready_o=1 next cycle; following MUL 6*7 -> 42.
//  6 Reset mid-MUL: reset_n low 1 cycle -> valid_o/result_o/busy_o 0 immediately, ready_o=1 after.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and operand-decode helpers for the M-extension execute unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL      = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DONE     = 3'd4
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

    // operand A is two's complement
    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // operand B is two's complement
    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, XLEN iterations.
// Ports: clk, reset_n, start (load operands), stall (hold), flush (abort),
//        dividend/divisor in; done_c (high on the edge of the last iteration),
//        quotient/remainder out (valid the cycle after done_c).
module div_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done_c,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dsr;
    logic [XLEN:0]    shifted;
    logic             ge;
    logic [XLEN-1:0]  rem_n;
    logic [XLEN-1:0]  quo_n;

    // one restoring step: shift next dividend bit into the partial remainder
    always_comb begin
        shifted = {remainder, quotient[XLEN-1]};
        ge      = (shifted >= {1'b0, dsr});
        rem_n   = ge ? XLEN'(shifted - {1'b0, dsr}) : shifted[XLEN-1:0];
        quo_n   = {quotient[XLEN-2:0], ge};
        done_c  = active && !stall && !flush && (cnt == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active    <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            cnt       <= '0;
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (active && !stall) begin
            quotient  <= quo_n;
            remainder <= rem_n;
            cnt       <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension execute unit: fixed-latency multiply, iterative divide/remainder.
// Ports: clk, reset_n; stall_i/flush_i pipeline control; valid_i/ready_o request
//        handshake with funct3_i, rs1_i, rs2_i; valid_o/result_o result; busy_o.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned PW     = 2 * XLEN + 2;
    localparam int unsigned MCNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN - 1){1'b0}}};

    muldiv_state_e     state, state_n;
    logic [MCNT_W-1:0] cnt, cnt_n;
    muldiv_op_e        op_q, op_n;
    logic [XLEN-1:0]   a_q, a_n, b_q, b_n;
    logic              special_q, special_n;
    logic [XLEN-1:0]   result_n;

    muldiv_op_e        in_op;
    logic              in_a_neg, in_b_neg, in_zero, in_ovf;
    logic [XLEN-1:0]   dvd_mag, dsr_mag;

    muldiv_op_e        m_op;
    logic [XLEN-1:0]   m_a, m_b;
    logic signed [XLEN:0]  m_a_ext, m_b_ext;
    logic signed [PW-1:0]  m_prod;
    logic [XLEN-1:0]   mul_res;
    logic              mul_unused;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    logic              div_start_c, div_done_c;
    logic [XLEN-1:0]   div_quo, div_rem;

    assign ready_o = (state == IDLE) && !stall_i && !flush_i;

    // request decode: magnitudes for the divider and the special cases
    always_comb begin
        in_op    = muldiv_op_e'(funct3_i);
        in_a_neg = is_signed_a(in_op) & rs1_i[XLEN-1];
        in_b_neg = is_signed_b(in_op) & rs2_i[XLEN-1];
        dvd_mag  = in_a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
        dsr_mag  = in_b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
        in_zero  = (rs2_i == '0);
        in_ovf   = is_signed_b(in_op) && (rs1_i == MIN_NEG) && (rs2_i == '1);
    end

    // single multiplier; fed from the inputs only when the result is due at accept
    always_comb begin
        m_op    = (state == IDLE) ? in_op : op_q;
        m_a     = (state == IDLE) ? rs1_i : a_q;
        m_b     = (state == IDLE) ? rs2_i : b_q;
        m_a_ext = {is_signed_a(m_op) & m_a[XLEN-1], m_a};
        m_b_ext = {is_signed_b(m_op) & m_b[XLEN-1], m_b};
        m_prod  = PW'(m_a_ext) * PW'(m_b_ext);
        mul_res = (m_op == OP_MUL) ? m_prod[XLEN-1:0] : m_prod[2*XLEN-1:XLEN];
    end

    assign mul_unused = ^m_prod[PW-1:2*XLEN];

    // sign correction of the unsigned divider result, plus the special cases
    always_comb begin
        a_neg = is_signed_a(op_q) & a_q[XLEN-1];
        b_neg = is_signed_b(op_q) & b_q[XLEN-1];
        q_fix = (a_neg ^ b_neg) ? (~div_quo + XLEN'(1)) : div_quo;
        r_fix = a_neg ? (~div_rem + XLEN'(1)) : div_rem;
        if (b_q == '0) begin
            fix_res = is_rem(op_q) ? a_q : '1;
        end else if (special_q) begin
            fix_res = is_rem(op_q) ? '0 : a_q;
        end else begin
            fix_res = is_rem(op_q) ? r_fix : q_fix;
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        op_n        = op_q;
        a_n         = a_q;
        b_n         = b_q;
        special_n   = special_q;
        result_n    = result_o;
        div_start_c = 1'b0;
        if (flush_i) begin
            state_n = IDLE;
        end else if (!stall_i) begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_n = in_op;
                        a_n  = rs1_i;
                        b_n  = rs2_i;
                        if (is_div(in_op)) begin
                            special_n = in_zero || in_ovf;
                            if (in_zero || in_ovf) begin
                                state_n = DIV_FIX;
                            end else begin
                                state_n     = DIV_CALC;
                                div_start_c = 1'b1;
                            end
                        end else if (MUL_LATENCY == 1) begin
                            state_n  = DONE;
                            result_n = mul_res;
                        end else begin
                            state_n = MUL;
                            cnt_n   = MCNT_W'(MUL_LATENCY - 2);
                        end
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        state_n  = DONE;
                        result_n = mul_res;
                    end else begin
                        cnt_n = cnt - MCNT_W'(1);
                    end
                end
                DIV_CALC: begin
                    if (div_done_c) begin
                        state_n = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state_n  = DONE;
                    result_n = fix_res;
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            special_q <= 1'b0;
            result_o  <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            a_q       <= a_n;
            b_q       <= b_n;
            special_q <= special_n;
            result_o  <= result_n;
            valid_o   <= (state_n == DONE);
            busy_o    <= (state_n != IDLE);
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start_c),
        .stall     (stall_i),
        .flush     (flush_i),
        .dividend  (dvd_mag),
        .divisor   (dsr_mag),
        .done_c    (div_done_c),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=4 and XLEN=32 instances).
module tb_muldiv_unit;

    logic clk;
    logic reset_n;

    logic       st4, fl4, v4, rdy4, vo4, busy4;
    logic [2:0] f4;
    logic [3:0] a4, b4, r4;

    logic        st32, fl32, v32, rdy32, vo32, busy32;
    logic [2:0]  f32;
    logic [31:0] a32, b32, r32;

    int total;
    int passed;

    muldiv_unit #(.XLEN(4), .MUL_LATENCY(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .stall_i(st4), .flush_i(fl4),
        .valid_i(v4), .ready_o(rdy4), .funct3_i(f4), .rs1_i(a4), .rs2_i(b4),
        .valid_o(vo4), .result_o(r4), .busy_o(busy4)
    );

    muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut32 (
        .clk(clk), .reset_n(reset_n), .stall_i(st32), .flush_i(fl32),
        .valid_i(v32), .ready_o(rdy32), .funct3_i(f32), .rs1_i(a32), .rs2_i(b32),
        .valid_o(vo32), .result_o(r32), .busy_o(busy32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // issue one op on the 4-bit unit; lat counts the accept edge as 1
    task automatic run4(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] res, output int lat);
        f4 = f; a4 = a; b4 = b; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        lat = 1;
        while (!vo4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = r4;
        @(posedge clk); #1;
    endtask

    task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        f32 = f; a32 = a; b32 = b; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 1;
        while (!vo32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = r32;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  res4;
        logic [31:0] res;
        int          lat;
        int          seen;

        total = 0; passed = 0;
        clk = 1'b0; reset_n = 1'b0;
        st4 = 0; fl4 = 0; v4 = 0; f4 = '0; a4 = '0; b4 = '0;
        st32 = 0; fl32 = 0; v32 = 0; f32 = '0; a32 = '0; b32 = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(vo32), 32'd0);
        chk("rst_result", r32, 32'd0);
        chk("rst_busy", 32'(busy32), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(rdy32), 32'd1);

        // 4-bit multiplies
        run4(3'b000, 4'hB, 4'h7, res4, lat);
        chk("mul4", 32'(res4), 32'hD);
        chk("mul4_lat", 32'(lat), 32'd2);
        run4(3'b001, 4'hB, 4'h7, res4, lat);
        chk("mulh4", 32'(res4), 32'hD);
        run4(3'b010, 4'hD, 4'hA, res4, lat);
        chk("mulhsu4", 32'(res4), 32'hE);
        run4(3'b011, 4'hD, 4'hA, res4, lat);
        chk("mulhu4", 32'(res4), 32'h8);
        chk("mulhu4_lat", 32'(lat), 32'd2);

        // 32-bit divide / remainder
        run32(3'b100, 32'hFFFF_FFF9, 32'd2, res, lat);
        chk("div_neg", res, 32'hFFFF_FFFD);
        chk("div_lat", 32'(lat), 32'd34);
        run32(3'b110, 32'hFFFF_FFF9, 32'd2, res, lat);
        chk("rem_neg", res, 32'hFFFF_FFFF);
        run32(3'b101, 32'd100, 32'd7, res, lat);
        chk("divu", res, 32'd14);
        run32(3'b111, 32'd100, 32'd7, res, lat);
        chk("remu", res, 32'd2);
        chk("remu_lat", 32'(lat), 32'd34);

        // special cases
        run32(3'b101, 32'd5, 32'd0, res, lat);
        chk("divu_zero", res, 32'hFFFF_FFFF);
        chk("divu_zero_lat", 32'(lat), 32'd2);
        run32(3'b111, 32'd5, 32'd0, res, lat);
        chk("remu_zero", res, 32'd5);
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        chk("div_ovf", res, 32'h8000_0000);
        chk("div_ovf_lat", 32'(lat), 32'd2);
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        chk("rem_ovf", res, 32'd0);

        // stall mid-divide, then stall while DONE
        f32 = 3'b101; a32 = 32'd100; b32 = 32'd7; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 1;
        chk("busy_ready", 32'(rdy32), 32'd0);
        repeat (5) begin @(posedge clk); #1; lat++; end
        st32 = 1'b1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        st32 = 1'b0;
        while (!vo32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_lat", 32'(lat), 32'd37);
        chk("stall_res", r32, 32'd14);
        st32 = 1'b1;
        #1;
        chk("stall_done_ready", 32'(rdy32), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_done_valid", 32'(vo32), 32'd1);
        chk("stall_done_res", r32, 32'd14);
        st32 = 1'b0;
        @(posedge clk); #1;
        chk("done_release_valid", 32'(vo32), 32'd0);

        // flush at cycle 10 of a divide
        f32 = 3'b100; a32 = 32'd1000; b32 = 32'd3; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        fl32 = 1'b1;
        #1;
        chk("flush_ready_low", 32'(rdy32), 32'd0);
        @(posedge clk); #1;
        fl32 = 1'b0;
        #1;
        chk("flush_ready", 32'(rdy32), 32'd1);
        chk("flush_busy", 32'(busy32), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (vo32) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run32(3'b000, 32'd6, 32'd7, res, lat);
        chk("mul_after_flush", res, 32'd42);
        chk("mul_after_flush_lat", 32'(lat), 32'd2);

        // reset in the middle of a multiply
        f32 = 3'b000; a32 = 32'd3; b32 = 32'd5; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("pre_rst_busy", 32'(busy32), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(vo32), 32'd0);
        chk("midrst_result", r32, 32'd0);
        chk("midrst_busy", 32'(busy32), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", 32'(rdy32), 32'd1);
        chk("postrst_valid", 32'(vo32), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
